mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter FAIR_LIMIT, default 4: max consecutive data grants while a fetch waits.
REQ-002 SHALL have parameter TIMEOUT, default 16: max wait cycles for MAck.
REQ-003 SHALL have port Clk  in  1  clock, rising edge.
REQ-004 SHALL have port Rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port IReq  in  1  fetch request, held until IReady.
REQ-006 SHALL have port IAddr  in  64  fetch byte address.
REQ-007 SHALL have port IReady  out  1  fetch done, one-cycle pulse.
REQ-008 SHALL have port IRdata  out  32  fetched instruction.
REQ-009 SHALL have port DReq  in  1  data request, held until DReady.
REQ-010 SHALL have port DWe  in  1  data write (1) / read (0).
REQ-011 SHALL have port DAddr  in  64  data byte address.
REQ-012 SHALL have port DWdata  in  64  store data.
REQ-013 SHALL have port DReady  out  1  data done, one-cycle pulse.
REQ-014 SHALL have port DRdata  out  64  load data.
REQ-015 SHALL have port MReq / MWe  out  1 / 1  memory request / write strobe.
REQ-016 SHALL have port MAddr / MWdata  out  64 / 64  memory address / write data.
REQ-017 SHALL have port MAck / MRdata  in  1 / 64  memory done / read data.
REQ-018 SHALL have port Err  out  1  timeout flag, pulses with the Ready.
REQ-019 SHALL have port StallIF / StallMEM  out  1 / 1  IReq&~IReady / DReq&~DReady.

Function
REQ-020 SHALL implement states IDLE, I_WAIT, D_WAIT, RESP.
REQ-021 IDLE: DReq sampled -> D_WAIT; else IReq -> I_WAIT; DReq wins over IReq unless the fairness rule applies.
REQ-022 Fairness: streak counter +1 on each D grant with IReq high, cleared on I grant or IReq low; streak==FAIR_LIMIT with IReq -> I_WAIT.
REQ-023 On grant, SHALL latch address/We/Wdata of the winner; M-outputs driven from latches, stable for the whole access.
REQ-024 MReq SHALL be high throughout I_WAIT/D_WAIT, low otherwise; MWe=0 in I_WAIT.
REQ-025 MAck sampled in X_WAIT -> RESP; MRdata latched at the same edge.
REQ-026 RESP lasts exactly one cycle: matching IReady or DReady high, then IDLE; new requests never granted from RESP.
REQ-027 IRdata = latched MRdata[63:32] if IAddr[2]=1, else [31:0]; DRdata = latched MRdata.
REQ-028 Latency: Req visible at edge N -> MReq from cycle N+1; MAck at edge M -> Ready in cycle M+1; minimum 3 cycles per access.
REQ-029 Timeout: wait counter cleared on grant, +1 per X_WAIT cycle; reaching TIMEOUT without MAck -> RESP with Err=1, read data 0.
REQ-030 MAck and timeout at the same edge: MAck wins, Err=0.
REQ-031 MAck outside X_WAIT SHALL be ignored.
REQ-032 Ready outputs SHALL never be high simultaneously.

Reset
REQ-033 Rst SHALL force IDLE, MReq=MWe=0, Ready/Err=0, all latches, data outputs and counters 0, immediately.
REQ-034 Reset mid-access SHALL abandon the access; no Ready is issued for it.

Structure
REQ-035 Package mem_arb_pkg SHALL hold the state enum and default FAIR_LIMIT/TIMEOUT constants.
REQ-036 The timeout counter SHALL be a sub-module arb_timer (clear, enable, expired).

Verification
REQ-037 IReq only, IAddr=0x104, MAck on first MReq cycle, MRdata=0xAABBCCDD_11223344 -> IReady in cycle 3, IRdata=0xAABBCCDD.
REQ-038 IReq and DReq high together, DWe=1, DAddr=0x40, DWdata=5 -> data served first (MWe=1, MAddr=0x40), then fetch.
REQ-039 DReq held continuously, IReq high, FAIR_LIMIT=4 -> 4 data accesses, then one fetch, then data resumes.
REQ-040 DReq, MAck never asserted, TIMEOUT=16 -> DReady and Err high in the cycle after the 16th wait cycle, DRdata=0.
REQ-041 Rst pulsed during D_WAIT -> MReq low immediately, no DReady; a new IReq afterwards completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_FAIR_LIMIT = 4;
  localparam int unsigned DEF_TIMEOUT    = 16;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned INSN_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  // Command captured from the winning port; drives the memory side for the whole access.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  // Pick the 32-bit instruction word out of a 64-bit beat using byte-address bit 2.
  function automatic logic [INSN_W-1:0] sel_insn(input logic [DATA_W-1:0] beat,
                                                 input logic              hi_word);
    return hi_word ? beat[DATA_W-1:INSN_W] : beat[INSN_W-1:0];
  endfunction

endpackage

// File: rtl/arb_timer.sv
// Wait-cycle counter; expired flags the LIMIT-th enabled cycle since the last clear.
module arb_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned LIMIT = DEF_TIMEOUT
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_c_o
);

  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired_c_o = enable_i && (cnt_q == CNT_W'(LIMIT - 1));

  // Counter holds at the terminal value; the owner leaves the wait state on expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CNT_W'(LIMIT - 1))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one memory port,
// with data priority bounded by a fairness streak and a per-access timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned FAIR_LIMIT = DEF_FAIR_LIMIT,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  output logic              IReady,
  output logic [INSN_W-1:0] IRdata,
  input  logic              DReq,
  input  logic              DWe,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWdata,
  output logic              DReady,
  output logic [DATA_W-1:0] DRdata,
  output logic              MReq,
  output logic              MWe,
  output logic [ADDR_W-1:0] MAddr,
  output logic [DATA_W-1:0] MWdata,
  input  logic              MAck,
  input  logic [DATA_W-1:0] MRdata,
  output logic              Err,
  output logic              StallIF,
  output logic              StallMEM
);

  localparam int unsigned STREAK_W = (FAIR_LIMIT > 0) ? $clog2(FAIR_LIMIT + 1) : 1;

  arb_state_e          state_q,  state_d;
  mem_cmd_t            cmd_q,    cmd_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [INSN_W-1:0]   irdata_q, irdata_d;
  logic [DATA_W-1:0]   drdata_q, drdata_d;
  logic                mreq_q,   mreq_d;
  logic                mwe_q,    mwe_d;
  logic                iready_q, iready_d;
  logic                dready_q, dready_d;
  logic                err_q,    err_d;

  logic grant_i_c;
  logic grant_d_c;
  logic waiting_c;
  logic expired_c;

  // Data wins unless the fetch port has been starved for FAIR_LIMIT data grants.
  assign grant_i_c = (state_q == IDLE) && IReq &&
                     (!DReq || (streak_q == STREAK_W'(FAIR_LIMIT)));
  assign grant_d_c = (state_q == IDLE) && DReq && !grant_i_c;
  assign waiting_c = (state_q == I_WAIT) || (state_q == D_WAIT);

  arb_timer #(
    .LIMIT(TIMEOUT)
  ) u_timer (
    .Clk        (Clk),
    .Rst        (Rst),
    .clear_i    (grant_i_c || grant_d_c),
    .enable_i   (waiting_c),
    .expired_c_o(expired_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    streak_d = streak_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    mreq_d   = 1'b0;
    mwe_d    = 1'b0;
    iready_d = 1'b0;
    dready_d = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_i_c) begin
          state_d  = I_WAIT;
          cmd_d    = '{we: 1'b0, addr: IAddr, wdata: '0};
          streak_d = '0;
          mreq_d   = 1'b1;
        end else if (grant_d_c) begin
          state_d = D_WAIT;
          cmd_d   = '{we: DWe, addr: DAddr, wdata: DWdata};
          mreq_d  = 1'b1;
          mwe_d   = DWe;
          if (IReq) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end
      end
      I_WAIT: begin
        if (MAck) begin
          state_d  = RESP;
          irdata_d = sel_insn(MRdata, cmd_q.addr[2]);
          iready_d = 1'b1;
        end else if (expired_c) begin
          state_d  = RESP;
          irdata_d = '0;
          iready_d = 1'b1;
          err_d    = 1'b1;
        end else begin
          mreq_d = 1'b1;
        end
      end
      D_WAIT: begin
        if (MAck) begin
          state_d  = RESP;
          drdata_d = MRdata;
          dready_d = 1'b1;
        end else if (expired_c) begin
          state_d  = RESP;
          drdata_d = '0;
          dready_d = 1'b1;
          err_d    = 1'b1;
        end else begin
          mreq_d = 1'b1;
          mwe_d  = cmd_q.we;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A fetch port that lets go owes nothing to fairness.
    if (!IReq) begin
      streak_d = '0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      streak_q <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      iready_q <= 1'b0;
      dready_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      streak_q <= streak_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      iready_q <= iready_d;
      dready_q <= dready_d;
      err_q    <= err_d;
    end
  end

  assign MReq     = mreq_q;
  assign MWe      = mwe_q;
  assign MAddr    = cmd_q.addr;
  assign MWdata   = cmd_q.wdata;
  assign IReady   = iready_q;
  assign IRdata   = irdata_q;
  assign DReady   = dready_q;
  assign DRdata   = drdata_q;
  assign Err      = err_q;
  assign StallIF  = IReq & ~iready_q;
  assign StallMEM = DReq & ~dready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: port agents, a scripted memory model and a response monitor.
module tb_mem_port_arbiter;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        IReq = 1'b0;
  logic [63:0] IAddr = '0;
  logic        IReady;
  logic [31:0] IRdata;
  logic        DReq = 1'b0;
  logic        DWe = 1'b0;
  logic [63:0] DAddr = '0;
  logic [63:0] DWdata = '0;
  logic        DReady;
  logic [63:0] DRdata;
  logic        MReq;
  logic        MWe;
  logic [63:0] MAddr;
  logic [63:0] MWdata;
  logic        MAck = 1'b0;
  logic [63:0] MRdata = '0;
  logic        Err;
  logic        StallIF;
  logic        StallMEM;

  mem_port_arbiter #(
    .FAIR_LIMIT(4),
    .TIMEOUT   (16)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .IReq(IReq), .IAddr(IAddr), .IReady(IReady), .IRdata(IRdata),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata),
    .DReady(DReady), .DRdata(DRdata),
    .MReq(MReq), .MWe(MWe), .MAddr(MAddr), .MWdata(MWdata),
    .MAck(MAck), .MRdata(MRdata),
    .Err(Err), .StallIF(StallIF), .StallMEM(StallMEM)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        is_d;
    logic [63:0] data;
    logic        err;
  } resp_t;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        chk_wdata;
    int          delay;
    logic [63:0] rdata;
  } mem_t;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } dreq_t;

  resp_t       exp_q[$];
  mem_t        mem_q[$];
  logic [63:0] iq[$];
  dreq_t       dq[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic i_active = 1'b0, d_active = 1'b0;
  int   i_start, d_start, i_cycles, d_cycles;
  logic spurious = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_mem(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic chk_w, input int delay, input logic [63:0] rdata);
    mem_t m;
    m = '{we: we, addr: addr, wdata: wdata, chk_wdata: chk_w, delay: delay, rdata: rdata};
    mem_q.push_back(m);
  endtask

  task automatic add_resp(input logic is_d, input logic [63:0] data, input logic err);
    resp_t r;
    r = '{is_d: is_d, data: data, err: err};
    exp_q.push_back(r);
  endtask

  task automatic add_dreq(input logic we, input logic [63:0] addr, input logic [63:0] wdata);
    dreq_t d;
    d = '{we: we, addr: addr, wdata: wdata};
    dq.push_back(d);
  endtask

  // Fetch agent: holds IReq until IReady, then presents the next queued fetch.
  always @(negedge Clk) begin
    if (Rst) begin
      IReq     = 1'b0;
      i_active = 1'b0;
    end else begin
      if (i_active && IReady) begin
        IReq     = 1'b0;
        i_active = 1'b0;
        i_cycles = cyc - i_start + 1;
      end
      if (!i_active && iq.size() != 0) begin
        IAddr    = iq.pop_front();
        IReq     = 1'b1;
        i_active = 1'b1;
        i_start  = cyc;
      end
    end
  end

  // Data agent: same handshake; back-to-back requests keep DReq high.
  always @(negedge Clk) begin
    dreq_t d;
    if (Rst) begin
      DReq     = 1'b0;
      d_active = 1'b0;
    end else begin
      if (d_active && DReady) begin
        DReq     = 1'b0;
        d_active = 1'b0;
        d_cycles = cyc - d_start + 1;
      end
      if (!d_active && dq.size() != 0) begin
        d        = dq.pop_front();
        DWe      = d.we;
        DAddr    = d.addr;
        DWdata   = d.wdata;
        DReq     = 1'b1;
        d_active = 1'b1;
        d_start  = cyc;
      end
    end
  end

  // Memory model: checks each access against the script and acks after its delay.
  mem_t cur;
  logic busy = 1'b0;
  int   mcnt = 0;
  always @(negedge Clk) begin
    if (Rst) begin
      busy = 1'b0;
      MAck = 1'b0;
    end else if (MReq) begin
      if (!busy) begin
        busy = 1'b1;
        mcnt = 0;
        chk("mem_access_expected", 64'(mem_q.size() != 0), 64'd1);
        if (mem_q.size() != 0) begin
          cur = mem_q.pop_front();
          chk("mem_we", 64'(MWe), 64'(cur.we));
          chk("mem_addr", MAddr, cur.addr);
          if (cur.chk_wdata) chk("mem_wdata", MWdata, cur.wdata);
        end else begin
          cur = '{we: MWe, addr: MAddr, wdata: MWdata, chk_wdata: 1'b0, delay: 0, rdata: '0};
        end
      end else begin
        chk("mem_addr_stable", MAddr, cur.addr);
        chk("mem_we_stable", 64'(MWe), 64'(cur.we));
      end
      MAck   = (mcnt == cur.delay);
      MRdata = MAck ? cur.rdata : 64'hBAD0_BAD0_BAD0_BAD0;
      mcnt++;
    end else begin
      busy   = 1'b0;
      MAck   = spurious;
      MRdata = 64'hDEAD_DEAD_DEAD_DEAD;
    end
  end

  // Response monitor: pops the scoreboard whenever a Ready pulse appears.
  always @(negedge Clk) begin
    resp_t e;
    if (!Rst) begin
      if (IReady || DReady) begin
        chk("ready_exclusive", 64'(IReady && DReady), 64'd0);
        chk("resp_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("resp_port_is_data", 64'(DReady), 64'(e.is_d));
          if (e.is_d) chk("drdata", DRdata, e.data);
          else        chk("irdata", {32'b0, IRdata}, e.data);
          chk("resp_err", 64'(Err), 64'(e.err));
        end
      end else if (Err) begin
        chk("err_without_ready", 64'(Err), 64'd0);
      end
    end
  end

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((iq.size() != 0 || dq.size() != 0 || i_active || d_active || exp_q.size() != 0)
           && n < budget) begin
      @(negedge Clk);
      n++;
    end
    chk({name, "_completed_in_budget"}, 64'(n < budget), 64'd1);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset values
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_mreq", 64'(MReq), 64'd0);
    chk("rst_mwe", 64'(MWe), 64'd0);
    chk("rst_ready", 64'({IReady, DReady, Err}), 64'd0);
    chk("rst_maddr", MAddr, 64'd0);
    chk("rst_mwdata", MWdata, 64'd0);
    chk("rst_rdata", {IRdata, DRdata[31:0]} | 64'(DRdata[63:32]), 64'd0);
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    chk("idle_stalls", 64'({StallIF, StallMEM}), 64'd0);

    // Fetch, MAck on first MReq cycle, upper word selected
    add_mem(1'b0, 64'h104, '0, 1'b0, 0, 64'hAABBCCDD_11223344);
    add_resp(1'b0, 64'hAABBCCDD, 1'b0);
    iq.push_back(64'h104);
    wait_done("fetch_hi", 50);
    chk("fetch_ready_cycle", 64'(i_cycles), 64'd3);

    // Fetch with delayed ack, lower word selected
    add_mem(1'b0, 64'h200, '0, 1'b0, 2, 64'h01234567_89ABCDEF);
    add_resp(1'b0, 64'h89ABCDEF, 1'b0);
    iq.push_back(64'h200);
    wait_done("fetch_lo", 50);
    chk("fetch_lo_ready_cycle", 64'(i_cycles), 64'd5);

    // Simultaneous requests: data write first, then fetch
    add_mem(1'b1, 64'h40, 64'd5, 1'b1, 0, 64'h0);
    add_resp(1'b1, 64'h0, 1'b0);
    add_mem(1'b0, 64'h8, '0, 1'b0, 1, 64'h11112222_33334444);
    add_resp(1'b0, 64'h33334444, 1'b0);
    add_dreq(1'b1, 64'h40, 64'd5);
    iq.push_back(64'h8);
    wait_done("data_priority", 60);

    // Fairness: four data grants, one fetch, then data resumes
    for (int k = 0; k < 4; k++) begin
      add_mem(1'b0, 64'h1000 + 64'(8 * k), '0, 1'b0, 0, 64'hD000 + 64'(k));
      add_resp(1'b1, 64'hD000 + 64'(k), 1'b0);
    end
    add_mem(1'b0, 64'h2004, '0, 1'b0, 0, 64'hFEEDFACE_00000000);
    add_resp(1'b0, 64'hFEEDFACE, 1'b0);
    for (int k = 4; k < 6; k++) begin
      add_mem(1'b0, 64'h1000 + 64'(8 * k), '0, 1'b0, 0, 64'hD000 + 64'(k));
      add_resp(1'b1, 64'hD000 + 64'(k), 1'b0);
    end
    for (int k = 0; k < 6; k++) add_dreq(1'b0, 64'h1000 + 64'(8 * k), '0);
    iq.push_back(64'h2004);
    wait_done("fairness", 120);

    // MAck while idle is ignored
    spurious = 1'b1;
    repeat (3) @(negedge Clk);
    spurious = 1'b0;
    chk("spurious_ack_no_mreq", 64'(MReq), 64'd0);
    @(posedge Clk);
    #1;

    // Data read with a 3-cycle ack delay
    add_mem(1'b0, 64'h88, '0, 1'b0, 3, 64'h0123456789ABCDEF);
    add_resp(1'b1, 64'h0123456789ABCDEF, 1'b0);
    add_dreq(1'b0, 64'h88, '0);
    wait_done("data_read", 50);
    chk("data_read_ready_cycle", 64'(d_cycles), 64'd6);

    // Data timeout: 16 wait cycles, Err with zero data
    add_mem(1'b0, 64'h300, '0, 1'b0, 1000, 64'h0);
    add_resp(1'b1, 64'h0, 1'b1);
    add_dreq(1'b0, 64'h300, '0);
    wait_done("data_timeout", 60);
    chk("timeout_ready_cycle", 64'(d_cycles), 64'd18);

    // MAck on the 16th wait cycle beats the timeout
    add_mem(1'b0, 64'h308, '0, 1'b0, 15, 64'h5A5A);
    add_resp(1'b1, 64'h5A5A, 1'b0);
    add_dreq(1'b0, 64'h308, '0);
    wait_done("ack_vs_timeout", 60);
    chk("ack_vs_timeout_cycle", 64'(d_cycles), 64'd18);

    // Fetch timeout clears the instruction word
    add_mem(1'b0, 64'h10, '0, 1'b0, 1000, 64'h0);
    add_resp(1'b0, 64'h0, 1'b1);
    iq.push_back(64'h10);
    wait_done("fetch_timeout", 60);

    // Reset during D_WAIT abandons the access
    add_mem(1'b0, 64'h400, '0, 1'b0, 1000, 64'h0);
    add_dreq(1'b0, 64'h400, '0);
    n = 0;
    while (!MReq && n < 20) begin
      @(negedge Clk);
      n++;
    end
    chk("rst_test_mreq_seen", 64'(MReq), 64'd1);
    chk("rst_test_stallmem", 64'(StallMEM), 64'd1);
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b1;
    #1;
    chk("rst_async_mreq", 64'(MReq), 64'd0);
    chk("rst_async_dready", 64'(DReady), 64'd0);
    chk("rst_async_maddr", MAddr, 64'd0);
    @(negedge Clk);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    chk("rst_irdata_cleared", 64'(IRdata), 64'd0);

    // Fetch after reset completes normally
    add_mem(1'b0, 64'h504, '0, 1'b0, 0, 64'h12345678_9ABCDEF0);
    add_resp(1'b0, 64'h12345678, 1'b0);
    iq.push_back(64'h504);
    wait_done("fetch_after_rst", 50);
    chk("fetch_after_rst_cycle", 64'(i_cycles), 64'd3);

    repeat (4) @(negedge Clk);
    chk("resp_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("mem_queue_drained", 64'(mem_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
